// File: rtl/alu_ctrl.sv
// Round-robin command sequencer for the 4-bit ripple ALU.
// Runs single-cycle ops directly and MUL as a 4-step shift-add.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] cmd0,
  input  logic [2:0] cmd1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [7:0] result,
  output logic       cout_o,
  output logic       err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_less,
  input  logic [3:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_set
);

  localparam logic [2:0] C_AND = 3'b000;
  localparam logic [2:0] C_OR  = 3'b001;
  localparam logic [2:0] C_ADD = 3'b010;
  localparam logic [2:0] C_SUB = 3'b011;
  localparam logic [2:0] C_SLT = 3'b100;
  localparam logic [2:0] C_NOR = 3'b101;
  localparam logic [2:0] C_MUL = 3'b110;
  localparam logic [2:0] C_RSV = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_t;

  state_t     state;
  logic       last;
  logic       id;
  logic [2:0] cmd;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [7:0] prod;
  logic [1:0] cnt;

  logic       pick1;
  logic [2:0] pcmd;
  logic [3:0] pa;
  logic [3:0] pb;
  logic [7:0] p_next;

  // On a tie the requester that was not served last wins.
  assign pick1 = req1 & (~req0 | ~last);
  assign pcmd  = pick1 ? cmd1 : cmd0;
  assign pa    = pick1 ? a1 : a0;
  assign pb    = pick1 ? b1 : b0;

  assign busy = (state != IDLE);

  assign p_next = prod[0] ? {alu_cout, alu_result, prod[3:1]}
                          : {1'b0, prod[7:1]};

  function automatic logic [3:0] op_of(input logic [2:0] c);
    logic [3:0] o;
    o = 4'b0000;
    case (c)
      C_AND:   o = 4'b0000;
      C_OR:    o = 4'b0001;
      C_ADD:   o = 4'b0010;
      C_SUB:   o = 4'b0110;
      C_SLT:   o = 4'b0111;
      C_NOR:   o = 4'b1100;
      default: o = 4'b0000;
    endcase
    return o;
  endfunction

  always_comb begin
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_op   = 4'h0;
    alu_less = 1'b0;
    if (state == EXEC && cmd != C_RSV) begin
      alu_a    = opa;
      alu_b    = opb;
      alu_op   = op_of(cmd);
      alu_less = (cmd == C_SLT) ? alu_set : 1'b0;
    end else if (state == MUL) begin
      alu_a  = prod[7:4];
      alu_b  = opa;
      alu_op = 4'b0010;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      id      <= 1'b0;
      cmd     <= 3'b000;
      opa     <= 4'h0;
      opb     <= 4'h0;
      prod    <= 8'h00;
      cnt     <= 2'd0;
      gnt     <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= 8'h00;
      cout_o  <= 1'b0;
      err     <= 1'b0;
    end else begin
      gnt     <= 2'b00;
      done    <= 1'b0;
      done_id <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt   <= pick1 ? 2'b10 : 2'b01;
            last  <= pick1;
            id    <= pick1;
            cmd   <= pcmd;
            opa   <= pa;
            opb   <= pb;
            prod  <= {4'h0, pb};
            cnt   <= 2'd0;
            state <= (pcmd == C_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          result  <= (cmd == C_RSV) ? 8'h00 : {4'h0, alu_result};
          cout_o  <= (cmd == C_ADD || cmd == C_SUB) & alu_cout;
          err     <= (cmd == C_RSV);
          done    <= 1'b1;
          done_id <= id;
          state   <= DONE;
        end
        MUL: begin
          prod <= p_next;
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            result  <= p_next;
            cout_o  <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b1;
            done_id <= id;
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl with a behavioural 4-bit ripple ALU attached.
// Expected results are queued at request time and popped on done.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [2:0] cmd0 = 3'd0;
  logic [2:0] cmd1 = 3'd0;
  logic [3:0] a0 = 4'd0;
  logic [3:0] b0 = 4'd0;
  logic [3:0] a1 = 4'd0;
  logic [3:0] b1 = 4'd0;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       done_id;
  logic [7:0] result;
  logic       cout_o;
  logic       err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic       alu_less;
  logic [3:0] alu_result;
  logic       alu_cout;
  logic       alu_set;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .cmd0(cmd0), .cmd1(cmd1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .cout_o(cout_o), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_less(alu_less),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_set(alu_set)
  );

  // Behavioural ripple ALU: ainv, binv/carry-in, then op select.
  logic [3:0] aa;
  logic [3:0] bb;
  logic [4:0] sum;
  assign aa = alu_op[3] ? ~alu_a : alu_a;
  assign bb = alu_op[2] ? ~alu_b : alu_b;
  assign sum = {1'b0, aa} + {1'b0, bb} + {4'b0, alu_op[2]};
  assign alu_set = sum[3];
  assign alu_cout = sum[4];
  assign alu_result = (alu_op[1:0] == 2'b00) ? (aa & bb) :
                      (alu_op[1:0] == 2'b01) ? (aa | bb) :
                      (alu_op[1:0] == 2'b10) ? sum[3:0] :
                      {3'b000, alu_less};

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       c;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t model(input logic i, input logic [2:0] c,
                                 input logic [3:0] a, input logic [3:0] b);
    exp_t x;
    logic [4:0] s;
    x.id = i;
    x.res = 8'h00;
    x.c = 1'b0;
    x.e = 1'b0;
    s = 5'd0;
    case (c)
      3'd0: x.res = {4'h0, a & b};
      3'd1: x.res = {4'h0, a | b};
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        x.res = {4'h0, s[3:0]};
        x.c = s[4];
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        x.res = {4'h0, s[3:0]};
        x.c = s[4];
      end
      3'd4: begin
        s = {1'b0, a} - {1'b0, b};
        x.res = {7'h00, s[3]};
      end
      3'd5: x.res = {4'h0, ~(a | b)};
      3'd6: x.res = {4'h0, a} * {4'h0, b};
      default: x.e = 1'b1;
    endcase
    return x;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic i, input logic [2:0] c,
                       input logic [3:0] a, input logic [3:0] b,
                       output logic [1:0] g);
    @(negedge clk);
    if (i) begin
      req1 = 1'b1; cmd1 = c; a1 = a; b1 = b;
    end else begin
      req0 = 1'b1; cmd0 = c; a0 = a; b0 = b;
    end
    sb.push_back(model(i, c, a, b));
    @(negedge clk);
    g = gnt;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({gnt, busy, done, done_id, result, cout_o, err} !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b id=%b res=%h c=%b err=%b want all 0",
               gnt, busy, done, done_id, result, cout_o, err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_less} !== 13'h0) begin
      failures++;
      $display("FAIL reset_alu_drive: got a=%h b=%h op=%h less=%b want 0",
               alu_a, alu_b, alu_op, alu_less);
    end
  endtask

  task automatic test_add();
    logic [1:0] g;
    int lat;
    bit ok;
    exp_t e;
    issue(1'b0, 3'd2, 4'd9, 4'd8, g);
    checks++;
    if (g !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL add_grant: got gnt=%b busy=%b want 01 1", g, busy);
    end
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != 2 || gnt !== 2'b00) begin
      failures++;
      $display("FAIL add_latency: got ok=%0d lat=%0d gnt=%b want 1 2 00", ok, lat, gnt);
    end
    e = sb.pop_front();
    checks++;
    if ({done_id, result, cout_o, err} !== e) begin
      failures++;
      $display("FAIL add_result: got id=%b res=%h c=%b err=%b want id=%b res=%h c=%b err=%b",
               done_id, result, cout_o, err, e.id, e.res, e.c, e.e);
    end
  endtask

  task automatic test_single_ops();
    logic [2:0] cs[6] = '{3'd3, 3'd4, 3'd4, 3'd5, 3'd0, 3'd1};
    logic [3:0] as[6] = '{4'd3, 4'd3, 4'd5, 4'd5, 4'hC, 4'h9};
    logic [3:0] bs[6] = '{4'd5, 4'd5, 4'd3, 4'd3, 4'hA, 4'h4};
    logic [1:0] g;
    int lat;
    bit ok;
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      issue(1'b1, cs[k], as[k], bs[k], g);
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++;
      if (g !== 2'b10 || !ok || lat != 2) begin
        failures++;
        $display("FAIL single_%0d_timing: got gnt=%b ok=%0d lat=%0d want 10 1 2", k, g, ok, lat);
      end
      checks++;
      if ({done_id, result, cout_o, err} !== e) begin
        failures++;
        $display("FAIL single_%0d_result: got id=%b res=%h c=%b err=%b want id=%b res=%h c=%b err=%b",
                 k, done_id, result, cout_o, err, e.id, e.res, e.c, e.e);
      end
    end
  endtask

  task automatic test_mul();
    logic       ids[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] as[4] = '{4'hF, 4'h0, 4'h6, 4'h9};
    logic [3:0] bs[4] = '{4'hF, 4'h7, 4'h3, 4'hD};
    logic [1:0] g;
    int lat;
    bit ok;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      issue(ids[k], 3'd6, as[k], bs[k], g);
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != 5) begin
        failures++;
        $display("FAIL mul_%0d_latency: got ok=%0d lat=%0d want 1 5", k, ok, lat);
      end
      checks++;
      if ({done_id, result, cout_o, err} !== e) begin
        failures++;
        $display("FAIL mul_%0d_result: got id=%b res=%h c=%b err=%b want id=%b res=%h c=%b err=%b",
                 k, done_id, result, cout_o, err, e.id, e.res, e.c, e.e);
      end
    end
  endtask

  task automatic test_reserved();
    logic [2:0] cs[2] = '{3'd7, 3'd2};
    logic [3:0] as[2] = '{4'hF, 4'd1};
    logic [3:0] bs[2] = '{4'hF, 4'd2};
    logic [1:0] g;
    int lat;
    bit ok;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, cs[k], as[k], bs[k], g);
      if (k == 0) begin
        checks++;
        if ({alu_a, alu_b, alu_op} !== 12'h0) begin
          failures++;
          $display("FAIL rsv_alu_idle: got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op);
        end
      end
      wait_done(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || {done_id, result, cout_o, err} !== e) begin
        failures++;
        $display("FAIL rsv_%0d_result: got ok=%0d res=%h c=%b err=%b want res=%h c=%b err=%b",
                 k, ok, result, cout_o, err, e.res, e.c, e.e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic pred;
    int grants;
    int lastg;
    exp_t e;
    apply_reset();
    @(negedge clk);
    req0 = 1'b1; cmd0 = 3'd0; a0 = 4'hC; b0 = 4'hA;
    req1 = 1'b1; cmd1 = 3'd1; a1 = 4'h3; b1 = 4'h4;
    pred = 1'b0;
    grants = 0;
    lastg = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (grants >= 6 && sb.size() == 0) break;
      @(negedge clk);
      if (gnt !== 2'b00) begin
        checks++;
        if (gnt !== (pred ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL rr_grant_%0d: got gnt=%b want %b", grants, gnt, pred ? 2'b10 : 2'b01);
        end
        if (lastg >= 0) begin
          checks++;
          if (cyc - lastg != 3) begin
            failures++;
            $display("FAIL rr_spacing_%0d: got %0d cycles want 3", grants, cyc - lastg);
          end
        end
        sb.push_back(pred ? model(1'b1, 3'd1, 4'h3, 4'h4)
                          : model(1'b0, 3'd0, 4'hC, 4'hA));
        lastg = cyc;
        pred = ~pred;
        grants++;
        if (grants == 6) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rr_unexpected_done: got done with empty queue want none");
        end else begin
          e = sb.pop_front();
          if ({done_id, result, cout_o, err} !== e) begin
            failures++;
            $display("FAIL rr_result: got id=%b res=%h want id=%b res=%h",
                     done_id, result, e.id, e.res);
          end
        end
      end
    end
    checks++;
    if (grants != 6 || sb.size() != 0) begin
      failures++;
      $display("FAIL rr_drain: got grants=%0d pending=%0d want 6 0", grants, sb.size());
    end
    req0 = 1'b0;
    req1 = 1'b0;
    sb.delete();
  endtask

  task automatic test_mid_reset();
    logic [1:0] g;
    int lat;
    bit ok;
    int seen;
    exp_t e;
    issue(1'b1, 3'd6, 4'hF, 4'hF, g);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0 || gnt !== 2'b00) begin
      failures++;
      $display("FAIL abort_state: got busy=%b res=%h done=%b gnt=%b want 0 00 0 00",
               busy, result, done, gnt);
    end
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
    end
    issue(1'b0, 3'd2, 4'd7, 4'd7, g);
    wait_done(lat, ok);
    e = sb.pop_front();
    checks++;
    if (g !== 2'b01 || !ok || lat != 2 || {done_id, result, cout_o, err} !== e) begin
      failures++;
      $display("FAIL after_abort: got gnt=%b ok=%0d lat=%0d res=%h want 01 1 2 %h",
               g, ok, lat, result, e.res);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_ops();
    test_mul();
    test_reserved();
    test_round_robin();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
